// File: rtl/masked_adder_pkg.sv
// Shared types and sizing helpers for the 2-share masked Kogge-Stone adder.
package masked_adder_pkg;

    typedef struct packed {
        logic p0;
        logic p1;
        logic g0;
        logic g1;
        logic hp0;
        logic hp1;
    } pg_bit_t;

    function automatic int unsigned levels_f(input int unsigned width);
        return $clog2(width);
    endfunction

    function automatic int unsigned rnd_w_f(input int unsigned width);
        return width * (1 + 3 * levels_f(width));
    endfunction

    // Offset of the 3-bit randomness slice for prefix cell (level, bit).
    function automatic int unsigned rnd_off_f(input int unsigned width,
                                              input int unsigned level,
                                              input int unsigned bit_idx);
        return width + 3 * (width * (level - 1) + bit_idx);
    endfunction

endpackage

// File: rtl/masked_black_cell.sv
// 2-share masked Kogge-Stone black cell: P = p & pl, G = g ^ (p & gl), outputs registered.
module masked_black_cell (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       p0,
    input  logic       p1,
    input  logic       g0,
    input  logic       g1,
    input  logic       pl0,
    input  logic       pl1,
    input  logic       gl0,
    input  logic       gl1,
    input  logic [2:0] r,
    output logic       q_p0,
    output logic       q_p1,
    output logic       q_g0,
    output logic       q_g1
);

    logic dp0, dp1, dt0, dt1;

    // DOM-indep products; cross terms are blinded by r0/r1 before the register
    always_comb begin
        dp0 = (p0 & pl0) ^ ((p0 & pl1) ^ r[0]);
        dp1 = (p1 & pl1) ^ ((p1 & pl0) ^ r[0]);
        dt0 = (p0 & gl0) ^ ((p0 & gl1) ^ r[1]);
        dt1 = (p1 & gl1) ^ ((p1 & gl0) ^ r[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p0 <= 1'b0;
            q_p1 <= 1'b0;
            q_g0 <= 1'b0;
            q_g1 <= 1'b0;
        end else if (en) begin
            q_p0 <= dp0;
            q_p1 <= dp1;
            q_g0 <= g0 ^ dt0 ^ r[2];
            q_g1 <= g1 ^ dt1 ^ r[2];
        end
    end

endmodule

// File: rtl/masked_ks_adder_pipe.sv
// First-order masked Kogge-Stone adder, one register per prefix level, valid/ready with global stall.
// Optional macro MASKED_ADD_CARRY_OUT_EN adds carry-out shares co0/co1.
module masked_ks_adder_pipe
    import masked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a0,
    input  logic [WIDTH-1:0]           a1,
    input  logic [WIDTH-1:0]           b0,
    input  logic [WIDTH-1:0]           b1,
    input  logic [rnd_w_f(WIDTH)-1:0]  rnd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           s0,
    output logic [WIDTH-1:0]           s1
`ifdef MASKED_ADD_CARRY_OUT_EN
    ,
    output logic                       co0,
    output logic                       co1
`endif
);

    localparam int unsigned LEVELS = levels_f(WIDTH);

    logic                    adv;
    logic [LEVELS:0]         vld;
    pg_bit_t [WIDTH-1:0]     st0_q;
    pg_bit_t [WIDTH-1:0]     st [LEVELS+1];
    logic [WIDTH-1:0]        fp0, fp1, fg0, fg1, fhp0, fhp1;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign st[0]    = st0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q <= '0;
            vld   <= '0;
        end else if (adv) begin
            vld <= {vld[LEVELS-1:0], in_valid};
            for (int unsigned i = 0; i < WIDTH; i++) begin
                st0_q[i].p0  <= a0[i] ^ b0[i];
                st0_q[i].p1  <= a1[i] ^ b1[i];
                st0_q[i].hp0 <= a0[i] ^ b0[i];
                st0_q[i].hp1 <= a1[i] ^ b1[i];
                st0_q[i].g0  <= (a0[i] & b0[i]) ^ ((a0[i] & b1[i]) ^ rnd[i]);
                st0_q[i].g1  <= (a1[i] & b1[i]) ^ ((a1[i] & b0[i]) ^ rnd[i]);
            end
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned SPAN = 1 << (l - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam int unsigned OFF = rnd_off_f(WIDTH, l, i);
            logic cp0, cp1, cg0, cg1, hp0, hp1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hp0 <= 1'b0;
                    hp1 <= 1'b0;
                end else if (adv) begin
                    hp0 <= st[l-1][i].hp0;
                    hp1 <= st[l-1][i].hp1;
                end
            end

            if (i >= SPAN) begin : g_cell
                masked_black_cell u_cell (
                    .clk  (clk),
                    .rst_n(rst_n),
                    .en   (adv),
                    .p0   (st[l-1][i].p0),
                    .p1   (st[l-1][i].p1),
                    .g0   (st[l-1][i].g0),
                    .g1   (st[l-1][i].g1),
                    .pl0  (st[l-1][i-SPAN].p0),
                    .pl1  (st[l-1][i-SPAN].p1),
                    .gl0  (st[l-1][i-SPAN].g0),
                    .gl1  (st[l-1][i-SPAN].g1),
                    .r    (rnd[OFF +: 3]),
                    .q_p0 (cp0),
                    .q_p1 (cp1),
                    .q_g0 (cg0),
                    .q_g1 (cg1)
                );
            end else begin : g_pass
                logic unused_r;
                assign unused_r = ^rnd[OFF +: 3];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cp0 <= 1'b0;
                        cp1 <= 1'b0;
                        cg0 <= 1'b0;
                        cg1 <= 1'b0;
                    end else if (adv) begin
                        cp0 <= st[l-1][i].p0;
                        cp1 <= st[l-1][i].p1;
                        cg0 <= st[l-1][i].g0;
                        cg1 <= st[l-1][i].g1;
                    end
                end
            end

            assign st[l][i] = '{p0: cp0, p1: cp1, g0: cg0, g1: cg1, hp0: hp0, hp1: hp1};
        end
    end

    always_comb begin
        fp0  = '0;
        fp1  = '0;
        fg0  = '0;
        fg1  = '0;
        fhp0 = '0;
        fhp1 = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            fp0[i]  = st[LEVELS][i].p0;
            fp1[i]  = st[LEVELS][i].p1;
            fg0[i]  = st[LEVELS][i].g0;
            fg1[i]  = st[LEVELS][i].g1;
            fhp0[i] = st[LEVELS][i].hp0;
            fhp1[i] = st[LEVELS][i].hp1;
        end
    end

    // Group propagates of the last level have no consumer; shares kept apart
    logic unused_p0, unused_p1;
    assign unused_p0 = ^fp0;
    assign unused_p1 = ^fp1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s0        <= '0;
            s1        <= '0;
`ifdef MASKED_ADD_CARRY_OUT_EN
            co0       <= 1'b0;
            co1       <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= vld[LEVELS];
            s0        <= fhp0 ^ {fg0[WIDTH-2:0], 1'b0};
            s1        <= fhp1 ^ {fg1[WIDTH-2:0], 1'b0};
`ifdef MASKED_ADD_CARRY_OUT_EN
            co0       <= fg0[WIDTH-1];
            co1       <= fg1[WIDTH-1];
`endif
        end
    end

`ifndef MASKED_ADD_CARRY_OUT_EN
    logic unused_co0, unused_co1;
    assign unused_co0 = fg0[WIDTH-1];
    assign unused_co1 = fg1[WIDTH-1];
`endif

endmodule

// File: tb/tb_masked_ks_adder_pipe.sv
// Directed and random self-checking bench for masked_ks_adder_pipe (WIDTH=8).
module tb_masked_ks_adder_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RND_W = 80;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a0, a1, b0, b1, s0, s1;
    logic [RND_W-1:0] rnd = '0;
`ifdef MASKED_ADD_CARRY_OUT_EN
    logic             co0, co1;
`endif

    int checks   = 0;
    int failures = 0;

    masked_ks_adder_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .b1       (b1),
        .rnd      (rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s0       (s0),
        .s1       (s1)
`ifdef MASKED_ADD_CARRY_OUT_EN
        ,
        .co0      (co0),
        .co1      (co1)
`endif
    );

    always #5 clk = ~clk;

    initial begin : rnd_gen
        logic [95:0] t;
        forever begin
            @(negedge clk);
            t   = {$urandom, $urandom, $urandom};
            rnd = t[RND_W-1:0];
        end
    end

    task automatic drive_op(input logic [7:0] av, input logic [7:0] bv);
        a0 = 8'($urandom);
        a1 = av ^ a0;
        b0 = 8'($urandom);
        b1 = bv ^ b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (s0 !== 8'h00) begin failures++; $display("FAIL reset_s0 got=%h exp=00", s0); end
        checks++; if (s1 !== 8'h00) begin failures++; $display("FAIL reset_s1 got=%h exp=00", s1); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        a0 = 8'h5A; a1 = 8'h00; b0 = 8'h3C; b1 = 8'h00; in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (k < 5) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency cyc=%0d got=%b exp=0", k, out_valid); end
            end else if (k == 5) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
                checks++; if ((s0 ^ s1) !== 8'h96) begin failures++; $display("FAIL basic_sum got=%h exp=96", s0 ^ s1); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", out_valid); end
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [8:0] full;
        bit         found;
        va = '{8'hFF, 8'h80, 8'h7F, 8'h00};
        vb = '{8'h01, 8'h80, 8'h01, 8'h00};
        for (int v = 0; v < 4; v++) begin
            full = {1'b0, va[v]} + {1'b0, vb[v]};
            drive_op(va[v], vb[v]);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                if (out_valid === 1'b1) found = 1'b1;
                else @(negedge clk);
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL wrap_timeout vec=%0d got=no_valid exp=valid", v);
            end else begin
                if ((s0 ^ s1) !== full[7:0]) begin failures++; $display("FAIL wrap_sum vec=%0d got=%h exp=%h", v, s0 ^ s1, full[7:0]); end
`ifdef MASKED_ADD_CARRY_OUT_EN
                checks++;
                if ((co0 ^ co1) !== full[8]) begin failures++; $display("FAIL wrap_co vec=%0d got=%b exp=%b", v, co0 ^ co1, full[8]); end
`endif
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [16];
        logic [7:0] av, bv;
        int got, first, last;
        got = 0; first = -1; last = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (got >= 16) begin
                    failures++; $display("FAIL b2b_extra got=%0d outputs exp=16", got + 1);
                end else if ((s0 ^ s1) !== exp[got]) begin
                    failures++; $display("FAIL b2b_sum idx=%0d got=%h exp=%h", got, s0 ^ s1, exp[got]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 16) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
                av = 8'(cyc * 37 + 11);
                bv = 8'(cyc * 113 + 200);
                exp[cyc] = av + bv;
                drive_op(av, bv);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (got !== 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", got); end
        checks++; if ((last - first) !== 15) begin failures++; $display("FAIL b2b_contiguous got=%0d exp=15", last - first); end
    endtask

    task automatic test_stall;
        logic [7:0] exp [5];
        logic [7:0] av, bv, c0, c1;
        int idx;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            av = 8'(i * 53 + 7);
            bv = 8'(i * 91 + 240);
            exp[i] = av + bv;
            drive_op(av, bv);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_head_valid got=%b exp=1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        checks++; if ((s0 ^ s1) !== exp[0]) begin failures++; $display("FAIL stall_head_sum got=%h exp=%h", s0 ^ s1, exp[0]); end
        c0 = s0; c1 = s1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (s0 !== c0) begin failures++; $display("FAIL stall_s0_frozen cyc=%0d got=%h exp=%h", k, s0, c0); end
            checks++; if (s1 !== c1) begin failures++; $display("FAIL stall_s1_frozen cyc=%0d got=%h exp=%h", k, s1, c1); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_frozen cyc=%0d got=%b exp=1", k, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_hold cyc=%0d got=%b exp=0", k, in_ready); end
        end
        out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (idx >= 5) begin
                    failures++; $display("FAIL stall_duplicate got=%0d outputs exp=5", idx + 1);
                end else if ((s0 ^ s1) !== exp[idx]) begin
                    failures++; $display("FAIL stall_resume_sum idx=%0d got=%h exp=%h", idx, s0 ^ s1, exp[idx]);
                end
                idx++;
            end
            @(negedge clk);
        end
        checks++; if (idx !== 5) begin failures++; $display("FAIL stall_count got=%0d exp=5", idx); end
    endtask

    task automatic test_reset_flush;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(8'($urandom), 8'($urandom));
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (s0 !== 8'h00) begin failures++; $display("FAIL flush_s0 got=%h exp=00", s0); end
        checks++; if (s1 !== 8'h00) begin failures++; $display("FAIL flush_s1 got=%h exp=00", s1); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale cyc=%0d got=%b exp=0", k, out_valid); end
        end
    endtask

    task automatic test_random;
        logic [7:0] q [$];
        logic [7:0] av, bv, e;
        int ones [8];
        int accepted, popped;
        accepted = 0; popped = 0;
        for (int b = 0; b < 8; b++) ones[b] = 0;
        for (int cyc = 0; cyc < 40000 && accepted < 10000; cyc++) begin
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected got=%h exp=none", s0 ^ s1);
                end else begin
                    e = q.pop_front();
                    if ((s0 ^ s1) !== e) begin failures++; $display("FAIL rand_sum got=%h exp=%h", s0 ^ s1, e); end
                end
                for (int b = 0; b < 8; b++) ones[b] += int'(s0[b]);
                popped++;
            end
            checks++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                failures++; $display("FAIL rand_in_ready got=%b exp=%b", in_ready, out_ready | ~out_valid);
            end
            av = 8'($urandom);
            bv = 8'($urandom);
            drive_op(av, bv);
            in_valid = ($urandom_range(3) != 0);
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(av + bv);
                accepted++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_drain_unexpected got=%h exp=none", s0 ^ s1);
                end else begin
                    e = q.pop_front();
                    if ((s0 ^ s1) !== e) begin failures++; $display("FAIL rand_drain_sum got=%h exp=%h", s0 ^ s1, e); end
                end
                for (int b = 0; b < 8; b++) ones[b] += int'(s0[b]);
                popped++;
            end
            @(negedge clk);
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d pending exp=0", q.size()); end
        checks++; if (accepted != 10000) begin failures++; $display("FAIL rand_accepted got=%0d exp=10000", accepted); end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (ones[b] * 10 < popped * 4 || ones[b] * 10 > popped * 6) begin
                failures++; $display("FAIL rand_s0_bias bit=%0d got=%0d/%0d exp=40..60 percent", b, ones[b], popped);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        test_reset;
        test_basic;
        test_wrap;
        test_back_to_back;
        test_stall;
        test_reset_flush;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
